// File: rtl/hilo_div_ctrl.sv
// HI/LO controller between EX and an iterative divider: decodes DIV/DIVU/MTHI/MTLO, launches the
// divider, commits q->LO / r->HI, and interlocks HI/LO users. Optional macro: DIV_ZERO_BYPASS_EN.
module hilo_div_ctrl #(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  HILO_RST = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              rd_req,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_start,
  output logic              div_sign,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic              div_busy,
  input  logic [DATA_W-1:0] div_q,
  input  logic [DATA_W-1:0] div_r
);

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t state;

  logic is_div, is_hilo_op, div_zero;

  assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
  assign is_hilo_op = is_div || (op == OP_MTHI) || (op == OP_MTLO);

`ifdef DIV_ZERO_BYPASS_EN
  assign div_zero = is_div && (rt_data == '0);
`else
  assign div_zero = 1'b0;
`endif

  // Anything that touches HI/LO must wait while a divide is in flight; in IDLE nothing stalls.
  assign stall = (state != IDLE) && (rd_req || is_hilo_op);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      hi           <= HILO_RST;
      lo           <= HILO_RST;
      div_start    <= 1'b0;
      div_sign     <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_div && div_zero) begin
            lo <= '1;
            hi <= rs_data;
          end else if (is_div) begin
            div_dividend <= rs_data;
            div_divisor  <= rt_data;
            div_sign     <= (op == OP_DIV);
            div_start    <= 1'b1;
            state        <= START;
          end else if (op == OP_MTHI) begin
            hi <= rs_data;
          end else if (op == OP_MTLO) begin
            lo <= rs_data;
          end
        end
        START: begin
          // Divider picks up start on the negedge inside this cycle.
          div_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (!div_busy) begin
            hi    <= div_r;
            lo    <= div_q;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
